// File: rtl/csr_file_m.sv
// rtl/csr_file_m.sv - machine-mode CSR file with vectored traps, 64-bit counters and platform IRQs
module csr_file_m #(
  parameter int          NUM_PLAT_IRQ = 4,
  parameter logic [31:0] MTVEC_RESET  = 32'h0000_0100,
  parameter logic [31:0] HART_ID      = 32'h0000_0000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [11:0]             csr_addr,
  input  logic [31:0]             csr_wdata,
  input  logic [1:0]              csr_op,
  input  logic                    csr_we,
  output logic [31:0]             csr_rdata,
  output logic                    csr_illegal,
  input  logic                    trap_enter,
  input  logic [31:0]             trap_pc,
  input  logic [31:0]             trap_cause,
  input  logic [31:0]             trap_tval,
  input  logic                    mret_exec,
  input  logic                    instr_retire,
  input  logic                    timer_irq,
  input  logic                    software_irq,
  input  logic                    external_irq,
  input  logic [NUM_PLAT_IRQ-1:0] plat_irq,
  output logic                    interrupt_pending,
  output logic [31:0]             interrupt_cause,
  output logic [31:0]             trap_target,
  output logic [31:0]             mepc_out
);

  localparam logic [31:0] PLAT_MASK = 32'(((64'd1 << NUM_PLAT_IRQ) - 64'd1) << 16);
  localparam logic [31:0] MIE_MASK  = PLAT_MASK | 32'h0000_0888;

  logic        mstatus_mie_q, mstatus_mie_d;
  logic        mstatus_mpie_q, mstatus_mpie_d;
  logic [31:0] mie_q, mie_d;
  logic [31:0] mip_q, mip_d;
  logic [31:0] mtvec_q, mtvec_d;
  logic [31:0] mcountinhibit_q, mcountinhibit_d;
  logic [31:0] mscratch_q, mscratch_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;
  logic [31:0] mtval_q, mtval_d;
  logic [63:0] mcycle_q, mcycle_d;
  logic [63:0] minstret_q, minstret_d;

  logic        mapped, read_only, wr_en;
  logic [31:0] wval, pend;
  logic [4:0]  plat_code, irq_code;

  // Read mux and address decode
  always_comb begin
    csr_rdata = 32'h0;
    mapped    = 1'b1;
    read_only = 1'b0;
    case (csr_addr)
      12'h300: csr_rdata = {19'b0, 2'b11, 3'b0, mstatus_mpie_q, 3'b0, mstatus_mie_q, 3'b0};
      12'h301: csr_rdata = 32'h4000_0100;
      12'h304: csr_rdata = mie_q;
      12'h305: csr_rdata = mtvec_q;
      12'h320: csr_rdata = mcountinhibit_q;
      12'h340: csr_rdata = mscratch_q;
      12'h341: csr_rdata = mepc_q;
      12'h342: csr_rdata = mcause_q;
      12'h343: csr_rdata = mtval_q;
      12'h344: csr_rdata = mip_q;
      12'hB00: csr_rdata = mcycle_q[31:0];
      12'hB80: csr_rdata = mcycle_q[63:32];
      12'hB02: csr_rdata = minstret_q[31:0];
      12'hB82: csr_rdata = minstret_q[63:32];
      12'hF11, 12'hF12, 12'hF13: read_only = 1'b1;
      12'hF14: begin
        csr_rdata = HART_ID;
        read_only = 1'b1;
      end
      default: mapped = 1'b0;
    endcase
  end

  assign csr_illegal = !mapped || (csr_we && read_only);
  assign wr_en       = csr_we && !csr_illegal && !trap_enter && !mret_exec;

  always_comb begin
    case (csr_op)
      2'b00:   wval = csr_wdata;
      2'b01:   wval = csr_rdata | csr_wdata;
      2'b10:   wval = csr_rdata & ~csr_wdata;
      default: wval = csr_rdata;
    endcase
  end

  // Ascending scan so the highest-numbered pending platform line wins
  assign pend = mip_q & mie_q;
  always_comb begin
    plat_code = 5'd0;
    for (int i = 0; i < NUM_PLAT_IRQ; i++) begin
      if (pend[16+i]) plat_code = 5'(16 + i);
    end
    if (pend[11])     irq_code = 5'd11;
    else if (pend[3]) irq_code = 5'd3;
    else if (pend[7]) irq_code = 5'd7;
    else              irq_code = plat_code;
  end

  assign interrupt_pending = mstatus_mie_q && (|pend);
  assign interrupt_cause   = interrupt_pending ? {1'b1, 26'b0, irq_code} : 32'h0;
  assign trap_target       = (mtvec_q[0] && interrupt_cause[31])
                           ? {mtvec_q[31:2], 2'b00} + {25'b0, interrupt_cause[4:0], 2'b00}
                           : {mtvec_q[31:2], 2'b00};
  assign mepc_out          = mepc_q;

  always_comb begin
    mstatus_mie_d   = mstatus_mie_q;
    mstatus_mpie_d  = mstatus_mpie_q;
    mie_d           = mie_q;
    mtvec_d         = mtvec_q;
    mcountinhibit_d = mcountinhibit_q;
    mscratch_d      = mscratch_q;
    mepc_d          = mepc_q;
    mcause_d        = mcause_q;
    mtval_d         = mtval_q;
    mcycle_d        = mcountinhibit_q[0] ? mcycle_q : mcycle_q + 64'd1;
    minstret_d      = (mcountinhibit_q[2] || !instr_retire) ? minstret_q : minstret_q + 64'd1;

    mip_d                    = 32'h0;
    mip_d[3]                 = software_irq;
    mip_d[7]                 = timer_irq;
    mip_d[11]                = external_irq;
    mip_d[16+:NUM_PLAT_IRQ]  = plat_irq;

    if (trap_enter) begin
      mepc_d         = trap_pc & ~32'h3;
      mcause_d       = interrupt_cause[31] ? interrupt_cause : trap_cause;
      mtval_d        = interrupt_cause[31] ? 32'h0 : trap_tval;
      mstatus_mpie_d = mstatus_mie_q;
      mstatus_mie_d  = 1'b0;
    end else if (mret_exec) begin
      mstatus_mie_d  = mstatus_mpie_q;
      mstatus_mpie_d = 1'b1;
    end else if (wr_en) begin
      case (csr_addr)
        12'h300: begin
          mstatus_mie_d  = wval[3];
          mstatus_mpie_d = wval[7];
        end
        12'h304: mie_d = wval & MIE_MASK;
        // Reserved mode encodings keep the previous mode; base always updates
        12'h305: mtvec_d = {wval[31:2], 1'b0,
                            (wval[1:0] == 2'b00) ? 1'b0 :
                            (wval[1:0] == 2'b01) ? 1'b1 : mtvec_q[0]};
        12'h320: mcountinhibit_d = wval & 32'h0000_0005;
        12'h340: mscratch_d = wval;
        12'h341: mepc_d     = wval & ~32'h3;
        12'h342: mcause_d   = wval;
        12'h343: mtval_d    = wval;
        12'hB00: mcycle_d   = {mcycle_q[63:32], wval};
        12'hB80: mcycle_d   = {wval, mcycle_q[31:0]};
        12'hB02: minstret_d = {minstret_q[63:32], wval};
        12'hB82: minstret_d = {wval, minstret_q[31:0]};
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mstatus_mie_q   <= 1'b0;
      mstatus_mpie_q  <= 1'b0;
      mie_q           <= 32'h0;
      mip_q           <= 32'h0;
      mtvec_q         <= MTVEC_RESET;
      mcountinhibit_q <= 32'h0;
      mscratch_q      <= 32'h0;
      mepc_q          <= 32'h0;
      mcause_q        <= 32'h0;
      mtval_q         <= 32'h0;
      mcycle_q        <= 64'h0;
      minstret_q      <= 64'h0;
    end else begin
      mstatus_mie_q   <= mstatus_mie_d;
      mstatus_mpie_q  <= mstatus_mpie_d;
      mie_q           <= mie_d;
      mip_q           <= mip_d;
      mtvec_q         <= mtvec_d;
      mcountinhibit_q <= mcountinhibit_d;
      mscratch_q      <= mscratch_d;
      mepc_q          <= mepc_d;
      mcause_q        <= mcause_d;
      mtval_q         <= mtval_d;
      mcycle_q        <= mcycle_d;
      minstret_q      <= minstret_d;
    end
  end

endmodule
